// File: rtl/rgd_rr_scheduler_if.sv
// rtl/rgd_rr_scheduler_if.sv - r/g/d handshake bundle between requesters and the round-robin scheduler
interface rgd_rr_scheduler_if #(
    parameter int N    = 4,
    parameter int W_ID = 2
);
    logic [N-1:0]    r;
    logic [N-1:0]    d;
    logic [N-1:0]    g;
    logic            busy;
    logic [W_ID-1:0] owner;
    logic            timeout;

    modport master (
        output r,
        output d,
        input  g,
        input  busy,
        input  owner,
        input  timeout
    );

    modport slave (
        input  r,
        input  d,
        output g,
        output busy,
        output owner,
        output timeout
    );
endinterface

// File: rtl/rgd_rr_scheduler.sv
// rtl/rgd_rr_scheduler.sv - N-way round-robin request/grant/done scheduler
// Optional grant watchdog enabled by defining GRANT_TIMEOUT_EN.
module rgd_rr_scheduler #(
    parameter int N           = 4,
    parameter int W_ID        = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input logic               clk,
    input logic               rst,
    rgd_rr_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // A misconfigured instance never grants instead of misbehaving silently.
    localparam bit CFG_OK = (N >= 2) && (N <= 16) && (W_ID == $clog2(N)) &&
                            (TIMEOUT_CYC >= 1) && (TIMEOUT_CYC <= 65535);
    localparam logic [W_ID-1:0] LAST_RST = W_ID'(N - 1);

    state_t          state;
    logic [N-1:0]    g_q;
    logic            busy_q;
    logic [W_ID-1:0] owner_q;
    logic [W_ID-1:0] last_q;
    logic            timeout_q;

    logic [W_ID-1:0] pick;
    logic [W_ID-1:0] cand;
    logic            any_req;
    logic            grant_req;
    logic            owner_r;
    logic            owner_d;

`ifdef GRANT_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] cnt;
`endif

    // Walk last+N down to last+1 so the final hit is the first set bit after last.
    always_comb begin
        pick    = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int i = N; i >= 1; i--) begin
            cand = W_ID'((int'(last_q) + i) % N);
            if (bus.r[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

    assign grant_req = any_req & CFG_OK;
    assign owner_r   = bus.r[owner_q];
    assign owner_d   = bus.d[owner_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            g_q       <= '0;
            busy_q    <= 1'b0;
            owner_q   <= '0;
            last_q    <= LAST_RST;
            timeout_q <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    g_q <= '0;
                    if (grant_req) begin
                        g_q     <= N'(1) << pick;
                        owner_q <= pick;
                        last_q  <= pick;
                        busy_q  <= 1'b1;
                        state   <= GRANT;
`ifdef GRANT_TIMEOUT_EN
                        cnt     <= '0;
`endif
                    end
                end
                GRANT: begin
                    // An abort (r dropped without d) releases exactly like done.
                    if (owner_d || !owner_r) begin
                        g_q   <= '0;
                        state <= RELEASE;
                    end
`ifdef GRANT_TIMEOUT_EN
                    else if (cnt == TO_LAST) begin
                        g_q       <= '0;
                        timeout_q <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
`endif
                end
                RELEASE: begin
                    g_q <= '0;
                    if (!owner_r && !owner_d) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    g_q    <= '0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.g       = g_q;
    assign bus.busy    = busy_q;
    assign bus.owner   = owner_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_rgd_rr_scheduler.sv
// tb/tb_rgd_rr_scheduler.sv - scoreboard bench for rgd_rr_scheduler
module tb_rgd_rr_scheduler;
    localparam int N  = 4;
    localparam int WI = 2;
    localparam int TO = 8;

    typedef struct packed {
        logic [3:0] g;
        logic       busy;
        logic [1:0] owner;
        logic       to;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    exp_t exp_q[$];

    rgd_rr_scheduler_if #(.N(N), .W_ID(WI)) bus ();

    rgd_rr_scheduler #(.N(N), .W_ID(WI), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [3:0] g, input logic b, input logic [1:0] o, input logic t);
        exp_t e;
        e.g = g; e.busy = b; e.owner = o; e.to = t;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: any change of g/busy, or a timeout pulse, is one DUT response.
    initial begin : monitor
        logic [3:0] prev_g;
        logic       prev_busy;
        exp_t       e;
        prev_g    = '0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.g !== prev_g || bus.busy !== prev_busy || bus.timeout === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output: g=%b busy=%b owner=%0d timeout=%b with nothing expected",
                             bus.g, bus.busy, bus.owner, bus.timeout);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.g !== e.g || bus.busy !== e.busy || bus.owner !== e.owner || bus.timeout !== e.to) begin
                        miscompares++;
                        $display("FAIL response: got g=%b busy=%b owner=%0d timeout=%b, expected g=%b busy=%b owner=%0d timeout=%b",
                                 bus.g, bus.busy, bus.owner, bus.timeout, e.g, e.busy, e.owner, e.to);
                    end
                end
            end
            prev_g    = bus.g;
            prev_busy = bus.busy;
        end
    end

    initial begin : stimulus
        int order [5] = '{0, 1, 2, 3, 0};
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        bus.r = '0;
        bus.d = '0;
        step(2);
        check("reset_g", 32'(bus.g), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_owner", 32'(bus.owner), 32'h0);
        check("reset_timeout", 32'(bus.timeout), 32'h0);
        rst = 1'b0;

        // d while idle is ignored
        bus.d = 4'b1111;
        step(2);
        bus.d = 4'b0000;
        step(1);

        // Single requester 2; stray d from non-owner 0 must not matter
        bus.r = 4'b0100;
        push_exp(4'b0100, 1'b1, 2'd2, 1'b0);
        step(1);
        bus.d = 4'b0001;
        step(2);
        bus.d = 4'b0000;
        step(2);
        bus.d = 4'b0100;
        push_exp(4'b0000, 1'b1, 2'd2, 1'b0);
        step(2);
        bus.r = 4'b0000;
        bus.d = 4'b0000;
        push_exp(4'b0000, 1'b0, 2'd2, 1'b0);
        step(1);

        // Skip and wrap from last=2
        bus.r = 4'b0011;
        push_exp(4'b0001, 1'b1, 2'd0, 1'b0);
        step(1);
        bus.d = 4'b0001;
        push_exp(4'b0000, 1'b1, 2'd0, 1'b0);
        step(1);
        bus.r = 4'b0010;
        bus.d = 4'b0000;
        push_exp(4'b0000, 1'b0, 2'd0, 1'b0);
        step(1);
        push_exp(4'b0010, 1'b1, 2'd1, 1'b0);
        step(1);

        // Abort by owner 1 with r[3] pending
        bus.r = 4'b1000;
        push_exp(4'b0000, 1'b1, 2'd1, 1'b0);
        step(1);
        push_exp(4'b0000, 1'b0, 2'd1, 1'b0);
        step(1);
        push_exp(4'b1000, 1'b1, 2'd3, 1'b0);
        step(1);
        bus.d = 4'b1000;
        push_exp(4'b0000, 1'b1, 2'd3, 1'b0);
        step(1);
        bus.r = 4'b0000;
        bus.d = 4'b0000;
        push_exp(4'b0000, 1'b0, 2'd3, 1'b0);
        step(1);

        // Round robin with all requesting from last=3
        bus.r = 4'b1111;
        push_exp(4'b0001, 1'b1, 2'd0, 1'b0);
        step(1);
        for (int k = 0; k < 4; k++) begin
            bus.d[order[k]] = 1'b1;
            push_exp(4'b0000, 1'b1, 2'(order[k]), 1'b0);
            step(1);
            bus.d[order[k]] = 1'b0;
            bus.r[order[k]] = 1'b0;
            push_exp(4'b0000, 1'b0, 2'(order[k]), 1'b0);
            step(1);
            bus.r[order[k]] = 1'b1;
            push_exp(4'b0001 << order[k + 1], 1'b1, 2'(order[k + 1]), 1'b0);
            step(1);
        end
        bus.d = 4'b0001;
        push_exp(4'b0000, 1'b1, 2'd0, 1'b0);
        step(1);
        bus.r = 4'b0000;
        bus.d = 4'b0000;
        push_exp(4'b0000, 1'b0, 2'd0, 1'b0);
        step(1);

        // Asynchronous reset in the middle of a grant to requester 1
        bus.r = 4'b0010;
        push_exp(4'b0010, 1'b1, 2'd1, 1'b0);
        step(1);
        @(negedge clk);
        #1;
        push_exp(4'b0000, 1'b0, 2'd0, 1'b0);
        rst = 1'b1;
        #1;
        check("async_rst_g", 32'(bus.g), 32'h0);
        check("async_rst_busy", 32'(bus.busy), 32'h0);
        bus.r = 4'b1111;
        step(1);
        rst = 1'b0;
        push_exp(4'b0001, 1'b1, 2'd0, 1'b0);
        step(1);
        bus.r = 4'b0000;
        push_exp(4'b0000, 1'b1, 2'd0, 1'b0);
        step(1);
        push_exp(4'b0000, 1'b0, 2'd0, 1'b0);
        step(1);

        // Owner 2 never raises d
        bus.r = 4'b0100;
        push_exp(4'b0100, 1'b1, 2'd2, 1'b0);
        step(1);
`ifdef GRANT_TIMEOUT_EN
        push_exp(4'b0000, 1'b1, 2'd2, 1'b1);
        step(TO);
        step(1);
        check("timeout_one_cycle", 32'(bus.timeout), 32'h0);
        check("timeout_g_low", 32'(bus.g), 32'h0);
        bus.r = 4'b0000;
        push_exp(4'b0000, 1'b0, 2'd2, 1'b0);
        step(1);
`else
        step(3 * TO);
        check("held_grant", 32'(bus.g), 32'h4);
        check("no_timeout", 32'(bus.timeout), 32'h0);
        bus.r = 4'b0000;
        push_exp(4'b0000, 1'b1, 2'd2, 1'b0);
        step(1);
        push_exp(4'b0000, 1'b0, 2'd2, 1'b0);
        step(1);
`endif

        step(4);
        check("responses_outstanding", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rgd_rr_scheduler.md
Name: rgd_rr_scheduler

Overview:
Clocked N-way Request-Grant-Done scheduler that shares one resource between N requesters. Each requester uses a 4-phase r/g/d handshake. Selection among pending requesters is round-robin. The block is the synchronous counterpart of the two-way RGD arbiter in async_lib and sits in front of any shared resource in the clocked domain. Requester r/d inputs are synchronous to clk; any synchronizers live outside this block.

Parameters:
N, 4, number of requesters (2..16).
W_ID, 2, width of the owner index; must equal clog2(N).
TIMEOUT_CYC, 255, maximum cycles a grant may be held (used only with GRANT_TIMEOUT_EN); range 1..2^16-1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
r  input  N  request per requester; level, held until the handshake completes.
d  input  N  done per requester; raised by the owner when finished with the resource.
g  output  N  grant per requester; registered, one-hot or all-zero.
busy  output  1  high while in GRANT or RELEASE.
owner  output  W_ID  index of the current or most recent grantee; valid while busy=1.
timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Reset (async, rst=1): g=0, busy=0, owner=0, timeout=0, state=IDLE, last=N-1 (requester 0 has highest priority after reset). Deassertion of rst is synchronous to clk.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If any r is high at an edge, pick the first set bit searching from last+1 upward with wrap (N-1 wraps to 0).
  - On that same edge: g[k]=1, owner=k, last=k, state=GRANT.
  - Latency: r sampled high at edge n gives g high after edge n.
  - With no requests, stay in IDLE and hold g=0.
- GRANT:
  - g[owner] is held.
  - If d[owner]=1 at an edge, then g=0 and state=RELEASE.
  - If r[owner]=0 before d[owner] (abort), treat it as done: g=0, state=RELEASE.
  - d or r changes from non-owners have no effect; their requests stay pending.
- RELEASE:
  - Hold g=0.
  - When r[owner]=0 and d[owner]=0 at an edge, go to IDLE.
  - Minimum turnaround: g falls 1 cycle after d is sampled high; the next grant is possible 2 edges after r/d are sampled low.
- d high on a requester that is not the owner, or while IDLE: ignored.
- Fairness: every continuously requesting requester is granted within N-1 other grants.
- owner and last change only on the IDLE->GRANT transition.
- N=1 is out of range; behaviour for it is not defined.

Optional Feature:
Macro GRANT_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on IDLE->GRANT and increments every cycle in GRANT.
  - When the counter equals TIMEOUT_CYC-1 and d[owner]=0, the next edge sets g=0, timeout=1 for exactly one cycle, and state=RELEASE.
  - If d[owner] and the timeout occur on the same edge, d wins (normal release, no timeout pulse).
- Not defined: no counter is built, timeout is tied to 0, and a grant may be held indefinitely.

Test Plan:
- Reset mid-grant: with g=4'b0010, assert rst asynchronously -> g=0, busy=0 immediately, without waiting for a clock edge. After release, assert r=4'b1111 -> first grant is g=4'b0001.
- Single requester: r[2]=1 at edge 0 -> g=4'b0100 after edge 0. d[2]=1 at edge 5 -> g=0 after edge 5. r[2], d[2] low at edge 7 -> IDLE after edge 7.
- Round robin: r=4'b1111 held, each owner completing d/r-drop/re-raise -> grant order 0,1,2,3,0; each g is exactly one-hot.
- Skip and wrap: last=2, r=4'b0011 -> g=4'b0001 (search 3, then wrap to 0).
- Abort: owner 1 drops r[1] without d[1] -> g=0 next cycle, state RELEASE, then IDLE. Pending r[3] is granted 2 edges later.
- Timeout (GRANT_TIMEOUT_EN, TIMEOUT_CYC=8): owner never raises d -> g drops after 8 cycles of grant and timeout=1 for one cycle. The same run without the macro -> g stays held and timeout stays 0.
